omr_sheet_reader: RTL and testbench
===================================

// Module: omr_sheet_reader
// PURPOSE
//  Front end of the OMR flow: collects optical bubble samples, one question row at a time, from the scanner head.
//  Majority-votes each bubble and rejects rows with more than one mark.
//  Packs the results into the student_answers word consumed by OMR_Machine (question q at bits [q*BUB_W +: BUB_W]).
//  Presents the finished sheet with a valid/ready handshake.
// PARAMETERS
//  NUM_Q      10    questions per sheet
//  BUB_W      4     bubbles per question (one-hot answer encoding)
//  N_SAMPLES  3     scanner passes per row
//  THRESH     2     minimum marked samples for a bubble to count as filled (1..N_SAMPLES)
//  TIMEOUT    255   max idle cycles between samples while scanning
// PORTS
//  clk              in   1              rising-edge clock
//  reset            in   1              asynchronous, active-high; clears all state
//  start            in   1              begin a new sheet (sampled in IDLE only)
//  row_valid        in   1              row_bubbles carries a sample
//  row_bubbles      in   BUB_W          one scanner pass of the current row, 1 = dark
//  row_ready        out  1              reader accepts a sample this cycle
//  student_answers  out  NUM_Q*BUB_W    packed answers, stable while sheet_valid
//  multi_mask       out  NUM_Q          bit q = row q had >1 filled bubble
//  sheet_valid      out  1              sheet complete
//  sheet_ready      in   1              downstream takes the sheet
//  busy             out  1              state != IDLE
//  timeout_err      out  1              one-cycle pulse on scan timeout
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; all counters, accumulators and answer/mask registers 0.
//  FSM states: IDLE, SCAN, DONE.
//   IDLE->SCAN on start. Entering SCAN clears student_answers, multi_mask, q_idx, s_idx and the vote counters.
//   SCAN->DONE when the final sample of row NUM_Q-1 is accepted. sheet_valid is high the next cycle (latency 1).
//   DONE->IDLE on sheet_valid && sheet_ready.
//   SCAN->IDLE on timeout. timeout_err pulses for that one cycle. Partial answers are discarded (cleared to 0).
//  row_ready = (state==SCAN). A sample is accepted on row_valid && row_ready. Samples arriving in IDLE or DONE are dropped.
//  Per bubble b: votes[b] += row_bubbles[b] on each accepted sample. Counter width is $clog2(N_SAMPLES+1).
//  On the N_SAMPLES-th accepted sample of a row:
//   - filled[b] = (votes[b] + current bit) >= THRESH.
//   - popcount(filled)==1: answer = filled.
//   - popcount==0: answer = 0 (blank).
//   - popcount>1: answer = 0 and multi_mask[q_idx] is set.
//   - The answer is written to slot q_idx. q_idx increments. s_idx and votes clear.
//   - Exception: on the final row, q_idx holds at NUM_Q-1 and does not wrap.
//  Idle counter: counts cycles in SCAN without an accepted sample. It resets on every accepted sample.
//   Timeout fires when the count reaches TIMEOUT.
//   An accepted sample in the same cycle as the threshold wins; no timeout is raised.
//  student_answers/multi_mask change only on a row commit or on entry to SCAN. They never change while sheet_valid=1.
//  start is ignored in SCAN and DONE. This includes the cycle of the DONE->IDLE transfer; start must be re-asserted in IDLE.
//  Reset mid-scan or mid-DONE: immediate return to IDLE with all outputs 0. No partial sheet is ever presented.
// STRUCTURE
//  Package omr_pkg:
//   - constants NUM_Q=10, BUB_W=4
//   - typedef answer_t = logic [BUB_W-1:0]
//   - enum reader_state_t {IDLE, SCAN, DONE}
//   - function onehot_or_zero(answer_t), also reused by OMR_Machine tests
//  Sub-module omr_bubble_voter:
//   - per-row vote counters and threshold compare
//   - inputs: sample, accept, clear
//   - outputs: filled[BUB_W], multi
// TESTING
//  1. Clean sheet: start; 10 rows x 3 samples of 4'b0001, 0010, 0100, 1000, ...
//     -> sheet_valid one cycle after the 30th accept; student_answers = matching packing; multi_mask = 0.
//  2. Noisy vote: row 0 samples 0001, 0000, 0001 -> answer 0001. Row 1 samples 0010, 0000, 0000 -> answer 0000 (blank), no mask bit.
//  3. Double mark: row 3 samples 0101 x3 -> slot 3 = 0000 and multi_mask = 10'b0000001000.
//     Feeding the result to OMR_Machine with key 0001 in slot 3 scores the question as wrong.
//  4. Backpressure: hold sheet_ready=0 for 20 cycles with row_valid toggling and start pulsed
//     -> sheet_valid and data stable, row_ready=0, no restart; release -> IDLE the next cycle.
//  5. Timeout: stop row_valid after row 4 for TIMEOUT cycles
//     -> timeout_err one-cycle pulse, state IDLE, student_answers = 0. A sample on the boundary cycle prevents the timeout.
//  6. Async reset asserted mid-row 6, between clock edges -> all outputs 0 immediately. A new start scans from q_idx 0.

Source files
------------

// File: rtl/omr_pkg.sv
// Shared types and constants for the OMR sheet reader and its consumers.
package omr_pkg;

    localparam int unsigned NUM_Q = 10;   // questions per sheet
    localparam int unsigned BUB_W = 4;    // bubbles per question

    typedef logic [BUB_W-1:0] answer_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } reader_state_t;

    // Pass through a legal answer (single mark or blank); anything else reads as blank.
    function automatic answer_t onehot_or_zero(input answer_t a);
        return ($countones(a) <= 1) ? a : answer_t'(0);
    endfunction

endpackage

// File: rtl/omr_bubble_voter.sv
// Per-row majority voter: accumulates dark samples per bubble and compares
// (stored votes + current sample) against THRESH so the row can commit on
// its final sample without an extra cycle.
//   clk, rst   clock, async active-high reset
//   sample     current scanner pass of the row
//   accept     sample is being taken this cycle
//   clear      drop all votes (row commit, scan entry, timeout)
//   filled_c   bubbles reaching THRESH including the current sample
//   multi_c    more than one bubble in filled_c
module omr_bubble_voter
    import omr_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 3,
    parameter int unsigned THRESH    = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  answer_t sample,
    input  logic    accept,
    input  logic    clear,
    output answer_t filled_c,
    output logic    multi_c
);

    localparam int unsigned CW = $clog2(N_SAMPLES + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned PW = $clog2(BUB_W + 1);

    logic [CW-1:0] votes [BUB_W];
    logic [PW-1:0] ones;

    // Vote counters; clear has priority since the committing sample is consumed via filled_c.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned b = 0; b < BUB_W; b++) votes[b] <= '0;
        end else if (clear) begin
            for (int unsigned b = 0; b < BUB_W; b++) votes[b] <= '0;
        end else if (accept) begin
            for (int unsigned b = 0; b < BUB_W; b++) votes[b] <= votes[b] + CW'(sample[b]);
        end
    end

    // Threshold compare and mark count.
    always_comb begin
        filled_c = '0;
        ones     = '0;
        for (int unsigned b = 0; b < BUB_W; b++) begin
            filled_c[b] = (SW'(votes[b]) + SW'(sample[b])) >= SW'(THRESH);
            ones        = ones + PW'(filled_c[b]);
        end
        multi_c = ones > PW'(1);
    end

endmodule

// File: rtl/omr_sheet_reader.sv
// OMR front end: collects N_SAMPLES scanner passes per question row, votes
// each bubble, rejects multi-marked rows and presents the packed sheet
// (question q at bits [q*BUB_W +: BUB_W]) with a valid/ready handshake.
//   clk, reset       clock, async active-high reset
//   start            begin a sheet (honoured in IDLE only)
//   row_valid        row_bubbles carries a sample
//   row_bubbles      one scanner pass, 1 = dark
//   row_ready        sample accepted this cycle when row_valid
//   student_answers  packed answers, stable while sheet_valid
//   multi_mask       per-question multi-mark flags
//   sheet_valid      sheet complete
//   sheet_ready      downstream takes the sheet
//   busy             not idle
//   timeout_err      one-cycle pulse on scan timeout
module omr_sheet_reader
    import omr_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 3,
    parameter int unsigned THRESH    = 2,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   row_valid,
    input  logic [BUB_W-1:0]       row_bubbles,
    output logic                   row_ready,
    output logic [NUM_Q*BUB_W-1:0] student_answers,
    output logic [NUM_Q-1:0]       multi_mask,
    output logic                   sheet_valid,
    input  logic                   sheet_ready,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int unsigned QW = $clog2(NUM_Q);
    localparam int unsigned SW = $clog2(N_SAMPLES + 1);
    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    reader_state_t state, state_next;
    logic [QW-1:0] q_idx;
    logic [SW-1:0] s_idx;
    logic [IW-1:0] idle_cnt;

    logic    accept_c, last_sample_c, last_row_c, commit_c;
    logic    timeout_c, scan_entry_c, clear_c, multi_c;
    answer_t filled_c, answer_c;

    omr_bubble_voter #(
        .N_SAMPLES (N_SAMPLES),
        .THRESH    (THRESH)
    ) u_voter (
        .clk      (clk),
        .rst      (reset),
        .sample   (row_bubbles),
        .accept   (accept_c),
        .clear    (clear_c),
        .filled_c (filled_c),
        .multi_c  (multi_c)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and control strobes. An accepted sample always beats the timeout.
    always_comb begin
        state_next    = state;
        scan_entry_c  = 1'b0;
        accept_c      = (state == SCAN) && row_valid;
        last_sample_c = (s_idx == SW'(N_SAMPLES - 1));
        last_row_c    = (q_idx == QW'(NUM_Q - 1));
        commit_c      = accept_c && last_sample_c;
        timeout_c     = (state == SCAN) && !row_valid && (idle_cnt == IW'(TIMEOUT - 1));
        answer_c      = multi_c ? answer_t'(0) : filled_c;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = SCAN;
                    scan_entry_c = 1'b1;
                end
            end
            SCAN: begin
                if (commit_c && last_row_c) state_next = DONE;
                else if (timeout_c)         state_next = IDLE;
            end
            DONE: begin
                if (sheet_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        clear_c = scan_entry_c || commit_c || timeout_c;
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_ready       <= 1'b0;
            busy            <= 1'b0;
            sheet_valid     <= 1'b0;
            timeout_err     <= 1'b0;
            student_answers <= '0;
            multi_mask      <= '0;
            q_idx           <= '0;
            s_idx           <= '0;
            idle_cnt        <= '0;
        end else begin
            row_ready   <= (state_next == SCAN);
            busy        <= (state_next != IDLE);
            sheet_valid <= (state_next == DONE);
            timeout_err <= timeout_c;
            if (scan_entry_c || timeout_c) begin
                student_answers <= '0;
                multi_mask      <= '0;
                q_idx           <= '0;
                s_idx           <= '0;
                idle_cnt        <= '0;
            end else if (accept_c) begin
                idle_cnt <= '0;
                if (last_sample_c) begin
                    s_idx <= '0;
                    for (int unsigned q = 0; q < NUM_Q; q++) begin
                        if (q_idx == QW'(q)) begin
                            student_answers[q*BUB_W +: BUB_W] <= answer_c;
                            multi_mask[q]                     <= multi_c;
                        end
                    end
                    // Final row holds q_idx instead of wrapping.
                    if (!last_row_c) q_idx <= q_idx + QW'(1);
                end else begin
                    s_idx <= s_idx + SW'(1);
                end
            end else if (state == SCAN) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_omr_sheet_reader.sv
// Self-checking bench for omr_sheet_reader: random sheets scored by a
// vote-count reference model, plus directed handshake/timeout/reset cases.
module tb_omr_sheet_reader;

    localparam int NQ = 10;
    localparam int BW = 4;
    localparam int NS = 3;
    localparam int TH = 2;
    localparam int TO = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              row_valid;
    logic [BW-1:0]     row_bubbles;
    logic              row_ready;
    logic [NQ*BW-1:0]  student_answers;
    logic [NQ-1:0]     multi_mask;
    logic              sheet_valid;
    logic              sheet_ready;
    logic              busy;
    logic              timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [BW-1:0]    smp [NQ][NS];
    logic [NQ*BW-1:0] exp_ans;
    logic [NQ-1:0]    exp_mask;

    omr_sheet_reader #(
        .N_SAMPLES (NS),
        .THRESH    (TH),
        .TIMEOUT   (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .row_valid       (row_valid),
        .row_bubbles     (row_bubbles),
        .row_ready       (row_ready),
        .student_answers (student_answers),
        .multi_mask      (multi_mask),
        .sheet_valid     (sheet_valid),
        .sheet_ready     (sheet_ready),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: count dark samples per bubble, threshold, classify by mark count.
    function automatic void compute_expected();
        logic [BW-1:0] filled;
        int cnt;
        exp_ans  = '0;
        exp_mask = '0;
        for (int q = 0; q < NQ; q++) begin
            filled = '0;
            for (int b = 0; b < BW; b++) begin
                cnt = 0;
                for (int s = 0; s < NS; s++) cnt += int'(smp[q][s][b]);
                filled[b] = (cnt >= TH);
            end
            if ($countones(filled) == 1) exp_ans[q*BW +: BW] = filled;
            if ($countones(filled) > 1)  exp_mask[q] = 1'b1;
        end
    endfunction

    // Rows built around a base answer (single, blank or random) with occasional bit noise.
    task automatic random_sheet(input bit noisy);
        logic [BW-1:0] base;
        int r;
        for (int q = 0; q < NQ; q++) begin
            r = $urandom_range(0, 5);
            if (r < 4)       base = BW'(32'd1 << r);
            else if (r == 4) base = '0;
            else             base = BW'($urandom);
            for (int s = 0; s < NS; s++) begin
                smp[q][s] = base;
                if (noisy && $urandom_range(0, 3) == 0)
                    smp[q][s] = base ^ BW'(32'd1 << $urandom_range(0, 3));
            end
        end
    endtask

    task automatic start_sheet();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Drive flat samples [from, to) with random idle gaps of up to max_gap cycles.
    task automatic feed(input int from, input int to, input int max_gap);
        int gap;
        for (int k = from; k < to; k++) begin
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                row_valid   = 1'b0;
                row_bubbles = BW'($urandom);
                step();
            end
            row_valid   = 1'b1;
            row_bubbles = smp[k / NS][k % NS];
            step();
        end
        row_valid = 1'b0;
    endtask

    task automatic take_sheet();
        sheet_ready = 1'b1;
        step();
        sheet_ready = 1'b0;
    endtask

    task automatic test_reset();
        step();
        vectors++;
        if ({row_ready, student_answers, multi_mask, sheet_valid, busy, timeout_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {row_ready, student_answers, multi_mask, sheet_valid, busy, timeout_err});
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        vectors++;
        if ({row_ready, sheet_valid, busy, timeout_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %b expected 0000",
                     {row_ready, sheet_valid, busy, timeout_err});
        end
    endtask

    task automatic test_clean_sheet();
        for (int q = 0; q < NQ; q++)
            for (int s = 0; s < NS; s++) smp[q][s] = BW'(32'd1 << (q % 4));
        compute_expected();
        start_sheet();
        vectors++;
        if ({busy, row_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL clean_scan_entry: got busy/row_ready %b expected 11", {busy, row_ready});
        end
        feed(0, NQ * NS - 1, 0);
        vectors++;
        if (sheet_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_early_valid: got %b expected 0", sheet_valid);
        end
        feed(NQ * NS - 1, NQ * NS, 0);
        vectors++;
        if (sheet_valid !== 1'b1 || row_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_valid_latency: got valid %b ready %b expected 1 0", sheet_valid, row_ready);
        end
        vectors++;
        if (student_answers !== exp_ans || multi_mask !== '0) begin
            miscompares++;
            $display("FAIL clean_answers: got %h/%h expected %h/0", student_answers, multi_mask, exp_ans);
        end
        take_sheet();
        vectors++;
        if ({busy, sheet_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL clean_release: got busy/valid %b expected 00", {busy, sheet_valid});
        end
    endtask

    task automatic test_noisy_vote();
        random_sheet(1'b1);
        smp[0][0] = 4'b0001; smp[0][1] = 4'b0000; smp[0][2] = 4'b0001;
        smp[1][0] = 4'b0010; smp[1][1] = 4'b0000; smp[1][2] = 4'b0000;
        compute_expected();
        start_sheet();
        feed(0, NQ * NS, 2);
        vectors++;
        if (student_answers[7:0] !== 8'h01 || multi_mask[1:0] !== 2'b00) begin
            miscompares++;
            $display("FAIL noisy_rows01: got %h mask %b expected 01 mask 00",
                     student_answers[7:0], multi_mask[1:0]);
        end
        vectors++;
        if (sheet_valid !== 1'b1 || student_answers !== exp_ans || multi_mask !== exp_mask) begin
            miscompares++;
            $display("FAIL noisy_sheet: got v%b %h/%h expected v1 %h/%h",
                     sheet_valid, student_answers, multi_mask, exp_ans, exp_mask);
        end
        take_sheet();
    endtask

    task automatic test_double_mark();
        random_sheet(1'b0);
        for (int q = 0; q < NQ; q++)
            for (int s = 0; s < NS; s++) smp[q][s] = BW'(32'd1 << (q % 4));
        for (int s = 0; s < NS; s++) smp[3][s] = 4'b0101;
        compute_expected();
        start_sheet();
        feed(0, NQ * NS, 1);
        vectors++;
        if (student_answers[15:12] !== 4'b0000 || multi_mask !== 10'b0000001000) begin
            miscompares++;
            $display("FAIL double_mark: got slot3 %b mask %b expected 0000 0000001000",
                     student_answers[15:12], multi_mask);
        end
        vectors++;
        if (student_answers !== exp_ans) begin
            miscompares++;
            $display("FAIL double_mark_sheet: got %h expected %h", student_answers, exp_ans);
        end
        take_sheet();
    endtask

    task automatic test_backpressure();
        random_sheet(1'b1);
        compute_expected();
        start_sheet();
        feed(0, NQ * NS, 1);
        for (int i = 0; i < 20; i++) begin
            row_valid   = 1'($urandom);
            row_bubbles = BW'($urandom);
            start       = (i % 5 == 0);
            sheet_ready = 1'b0;
            step();
            vectors++;
            if (sheet_valid !== 1'b1 || row_ready !== 1'b0 || busy !== 1'b1 ||
                student_answers !== exp_ans || multi_mask !== exp_mask) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d]: got v%b r%b b%b %h/%h expected v1 r0 b1 %h/%h",
                         i, sheet_valid, row_ready, busy, student_answers, multi_mask, exp_ans, exp_mask);
            end
        end
        row_valid   = 1'b0;
        start       = 1'b1;
        sheet_ready = 1'b1;
        step();
        start       = 1'b0;
        sheet_ready = 1'b0;
        vectors++;
        if ({busy, sheet_valid, row_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL backpressure_release: got b/v/r %b expected 000", {busy, sheet_valid, row_ready});
        end
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_no_restart: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_random_sheets();
        for (int n = 0; n < 6; n++) begin
            random_sheet(n % 2 == 0);
            compute_expected();
            start_sheet();
            feed(0, NQ * NS, 3);
            vectors++;
            if (sheet_valid !== 1'b1 || student_answers !== exp_ans || multi_mask !== exp_mask) begin
                miscompares++;
                $display("FAIL random_sheet[%0d]: got v%b %h/%h expected v1 %h/%h",
                         n, sheet_valid, student_answers, multi_mask, exp_ans, exp_mask);
            end
            take_sheet();
        end
    endtask

    task automatic test_timeout();
        logic [NQ*BW-1:0] part_ans;
        logic [NQ-1:0]    part_mask;
        random_sheet(1'b1);
        compute_expected();
        part_ans  = exp_ans  & {{(NQ-5)*BW{1'b0}}, {5*BW{1'b1}}};
        part_mask = exp_mask & {{(NQ-5){1'b0}}, 5'b11111};
        start_sheet();
        feed(0, 5 * NS, 1);
        vectors++;
        if (student_answers !== part_ans || multi_mask !== part_mask) begin
            miscompares++;
            $display("FAIL timeout_partial: got %h/%h expected %h/%h",
                     student_answers, multi_mask, part_ans, part_mask);
        end
        for (int i = 0; i < TO - 1; i++) begin
            row_bubbles = BW'($urandom);
            step();
        end
        vectors++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: got busy %b err %b expected 1 0", busy, timeout_err);
        end
        step();
        vectors++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || row_ready !== 1'b0 ||
            student_answers !== '0 || multi_mask !== '0) begin
            miscompares++;
            $display("FAIL timeout_fire: got err %b busy %b ready %b %h/%h expected 1 0 0 0/0",
                     timeout_err, busy, row_ready, student_answers, multi_mask);
        end
        step();
        vectors++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_pulse_width: got err %b busy %b expected 0 0", timeout_err, busy);
        end
    endtask

    task automatic test_timeout_boundary();
        random_sheet(1'b1);
        compute_expected();
        start_sheet();
        for (int i = 0; i < TO - 1; i++) step();
        feed(0, 1, 0);
        vectors++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL boundary_first: got busy %b err %b expected 1 0", busy, timeout_err);
        end
        for (int i = 0; i < TO - 1; i++) step();
        feed(1, NQ * NS, 0);
        vectors++;
        if (sheet_valid !== 1'b1 || timeout_err !== 1'b0 ||
            student_answers !== exp_ans || multi_mask !== exp_mask) begin
            miscompares++;
            $display("FAIL boundary_sheet: got v%b err %b %h/%h expected v1 err 0 %h/%h",
                     sheet_valid, timeout_err, student_answers, multi_mask, exp_ans, exp_mask);
        end
        take_sheet();
    endtask

    task automatic test_async_reset();
        random_sheet(1'b1);
        compute_expected();
        start_sheet();
        feed(0, 6 * NS + 1, 1);
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if ({row_ready, student_answers, multi_mask, sheet_valid, busy, timeout_err} !== '0) begin
            miscompares++;
            $display("FAIL async_reset_immediate: got %h expected 0",
                     {row_ready, student_answers, multi_mask, sheet_valid, busy, timeout_err});
        end
        #2;
        reset = 1'b0;
        step();
        vectors++;
        if ({busy, sheet_valid, row_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset_idle: got b/v/r %b expected 000", {busy, sheet_valid, row_ready});
        end
        start_sheet();
        feed(0, NQ * NS, 1);
        vectors++;
        if (sheet_valid !== 1'b1 || student_answers !== exp_ans || multi_mask !== exp_mask) begin
            miscompares++;
            $display("FAIL async_reset_rescan: got v%b %h/%h expected v1 %h/%h",
                     sheet_valid, student_answers, multi_mask, exp_ans, exp_mask);
        end
        take_sheet();
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        row_valid   = 1'b0;
        row_bubbles = '0;
        sheet_ready = 1'b0;
        test_reset();
        test_clean_sheet();
        test_noisy_vote();
        test_double_mark();
        test_backpressure();
        test_random_sheets();
        test_timeout();
        test_timeout_boundary();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
